alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Two-requester controller that time-shares one instance of the team's combinational ALU (DATA_W-bit operands, 3-bit opcode, 2*DATA_W-bit result).
- Per requester: valid/ready request channel. Shared: one valid/ready response channel tagged with the requester id.
- Round-robin arbitration, operand capture, one registered execute cycle, held response.
- Sits between the two issuing units and the ALU; no other block drives the ALU.

Parameters:
- DATA_W, 4, operand width.
- OP_W, DATA_W-1, opcode width (3 at default).
- RES_W, 2*DATA_W, result width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset (sampled on clk; no asynchronous path)
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester accept strobe, at most one bit high
- req_a0, req_b0  in  DATA_W  requester 0 operands
- req_op0  in  OP_W  requester 0 opcode
- req_a1, req_b1  in  DATA_W  requester 1 operands
- req_op1  in  OP_W  requester 1 opcode
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester id of the response
- rsp_data  out  RES_W  result
- rsp_err  out  1  illegal opcode flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, req_ready=0.
  - Reset mid-operation drops the in-flight op silently. No response is issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant gnt: the only valid requester, or rr_ptr when both are valid.
  - req_ready[gnt]=1 combinationally in that cycle. At the edge, capture a/b/op of gnt and gnt into internal registers, then go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC (1 cycle):
  - ALU is driven from the captured registers; its output is registered into rsp_data/rsp_err/rsp_id.
  - Go to RESP.
- RESP:
  - rsp_valid=1. rsp_data/rsp_id/rsp_err are held stable until rsp_ready=1 at an edge.
  - On that edge: rsp_valid drops to 0, rr_ptr becomes ~served_id, go to IDLE.
- Latency and throughput:
  - Accept at edge N gives rsp_valid high in cycle N+2 when rsp_ready is held high.
  - Maximum throughput is one op per 3 cycles.
  - No new request is accepted while in EXEC or RESP.
- Requester rules:
  - Requesters hold valid and operands stable until ready.
  - req_ready is a single-cycle pulse.
  - A requester deasserting valid before grant is legal and is not an error.
- Result rules:
  - Opcodes: 0=AND, 1=OR, 2=NAND, 3=NOR, 4=XOR, 5=XNOR.
  - Operands are zero-extended to RES_W before the operation. NAND/NOR/XNOR therefore set the upper DATA_W bits to all ones; AND/OR/XOR set them to zero.
- Illegal opcodes 6 and 7: rsp_data forced to 0 (the ALU output is ignored); the response is still issued.
- Simultaneous events:
  - Both valid in IDLE: rr_ptr wins.
  - rsp_ready high in the same cycle a new request arrives: the request waits until IDLE; no bypass.

Optional Feature:
- Macro: ALU_SHARE_CTRL_ERR_EN.
- Defined: rsp_err=1 with the response of an illegal opcode (6 or 7), otherwise 0.
- Undefined: rsp_err is tied to 0; illegal opcodes still return rsp_data=0.

Decomposition:
- Package alu_share_pkg holds:
  - opcode localparams OP_AND..OP_XNOR (OP_AND=0 ... OP_XNOR=5)
  - state enum IDLE/EXEC/RESP
  - default widths
- Natural sub-module: rr_arb2 (2-way round-robin grant from req_valid and rr_ptr, one-hot output).
- The ALU is instantiated unchanged.

Test Plan:
- Req0 only, a=4'hC, b=4'hA, op=2 (NAND), rsp_ready=1: req_ready=2'b01 for one cycle; rsp_valid 2 cycles later with rsp_data=8'hF7, rsp_id=0.
- Both valid after reset: req0 op=0 (C,A), req1 op=5 (C,A).
  - First response id=0, data=8'h08.
  - Second response id=1, data=8'hF9.
  - Third grant returns to req0 if both stay valid.
- Backpressure: rsp_ready=0 for 5 cycles in RESP. rsp_valid, rsp_data and rsp_id stay stable; no req_ready pulses; completion occurs on the first rsp_ready=1 edge.
- Illegal op=7 from req1:
  - rsp_data=0.
  - rsp_err=1 with ALU_SHARE_CTRL_ERR_EN defined, 0 without it.
- rst_n=0 for one cycle during EXEC:
  - Next cycle: state IDLE, rsp_valid=0, rr_ptr=0, no response for the dropped op.
  - A pending req1 is then granted normally.
- Single requester back-to-back (req1 always valid, 10 ops): all granted to req1; responses spaced 3 cycles apart with rsp_ready=1.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared widths, opcode encodings and FSM state encodings for the ALU sharing controller.
package alu_share_pkg;
    localparam int DATA_W_DEF = 4;
    localparam int OP_W_DEF   = DATA_W_DEF - 1;
    localparam int RES_W_DEF  = 2 * DATA_W_DEF;

    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_NAND = 2;
    localparam int OP_NOR  = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_XNOR = 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    function automatic logic op_illegal(input int op);
        return op > OP_XNOR;
    endfunction
endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Combinational bitwise ALU; operands are zero-extended to the result width first.
// Zero latency; unknown opcodes give zero.
module alu
    import alu_share_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = DATA_W - 1,
    parameter int RES_W  = 2 * DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [RES_W-1:0]  y
);
    logic [RES_W-1:0] ax;
    logic [RES_W-1:0] bx;

    assign ax = RES_W'(a);
    assign bx = RES_W'(b);

    always_comb begin
        y = '0;
        case (int'(op))
            OP_AND:  y = ax & bx;
            OP_OR:   y = ax | bx;
            OP_NAND: y = ~(ax & bx);
            OP_NOR:  y = ~(ax | bx);
            OP_XOR:  y = ax ^ bx;
            OP_XNOR: y = ~(ax ^ bx);
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/alu_share_ctrl_rr_arb2.sv
// 2-way round-robin arbiter: a lone requester wins, ptr breaks ties; one-hot grant.
// Purely combinational, no backpressure of its own.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = valid;
        if (valid == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU between two requesters with round-robin grant; rsp_err gated by ALU_SHARE_CTRL_ERR_EN.
// Latency: accept at edge N -> rsp_valid in cycle N+2; one op per 3 cycles at best.
// Backpressure: response held until rsp_ready; no request accepted outside IDLE.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = DATA_W - 1,
    parameter int RES_W  = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [OP_W-1:0]   req_op1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_err
);
    logic [1:0]        state;
    logic              rr_ptr;
    logic [1:0]        gnt;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic [OP_W-1:0]   cap_op;
    logic              cap_id;
    logic              cap_illegal;
    logic [RES_W-1:0]  alu_y;

    rr_arb2 u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .gnt   (gnt)
    );

    // Ready is suppressed during reset so a requester never sees an accept that was not captured.
    assign req_ready = (rst_n && state == IDLE) ? gnt : 2'b00;

    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .RES_W  (RES_W)
    ) u_alu (
        .a  (cap_a),
        .b  (cap_b),
        .op (cap_op),
        .y  (alu_y)
    );

    assign cap_illegal = op_illegal(int'(cap_op));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_op    <= '0;
            cap_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        cap_a  <= gnt[1] ? req_a1  : req_a0;
                        cap_b  <= gnt[1] ? req_b1  : req_b0;
                        cap_op <= gnt[1] ? req_op1 : req_op0;
                        cap_id <= gnt[1];
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= cap_illegal ? '0 : alu_y;
                    rsp_id    <= cap_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= ~rsp_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (state == EXEC) begin
            rsp_err <= cap_illegal;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: vector table of single-requester ops plus arbitration,
// backpressure, reset-during-EXEC and back-to-back sequences.
module tb_alu_share_ctrl;
`ifdef ALU_SHARE_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0] req_op0, req_op1;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    alu_share_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_op0   (req_op0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_op1   (req_op1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [7:0] exp_data;
        logic       ill;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        if (id == 0) begin
            req_a0 = a; req_b0 = b; req_op0 = op;
        end else begin
            req_a1 = a; req_b1 = b; req_op1 = op;
        end
    endtask

    // One op from a single requester with rsp_ready held high; starts from IDLE.
    task automatic txn(input int id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic [7:0] ed, input logic ill);
        @(negedge clk);
        set_req(id, a, b, op);
        set_req(1 - id, ~a, ~b, 3'd4);
        req_valid = (id == 0) ? 2'b01 : 2'b10;
        rsp_ready = 1'b1;
        #1;
        check("txn_grant", req_ready, (id == 0) ? 2'b01 : 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("txn_exec_vld", rsp_valid, 1'b0);
        check("txn_exec_rdy", req_ready, 2'b00);
        @(negedge clk);
        #1;
        check("txn_rsp_vld", rsp_valid, 1'b1);
        check("txn_rsp_id", rsp_id, id[0]);
        check("txn_rsp_data", rsp_data, ed);
        check("txn_rsp_err", rsp_err, ill & ERR_EN);
    endtask

    // One reset edge; returns at the negedge where rst_n is released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{0, 4'hC, 4'hA, 3'd2, 8'hF7, 1'b0};
        vt[1]  = '{0, 4'hC, 4'hA, 3'd0, 8'h08, 1'b0};
        vt[2]  = '{1, 4'hC, 4'hA, 3'd1, 8'h0E, 1'b0};
        vt[3]  = '{1, 4'hC, 4'hA, 3'd3, 8'hF1, 1'b0};
        vt[4]  = '{0, 4'hC, 4'hA, 3'd4, 8'h06, 1'b0};
        vt[5]  = '{1, 4'hC, 4'hA, 3'd5, 8'hF9, 1'b0};
        vt[6]  = '{1, 4'hC, 4'hA, 3'd7, 8'h00, 1'b1};
        vt[7]  = '{0, 4'hC, 4'hA, 3'd6, 8'h00, 1'b1};
        vt[8]  = '{0, 4'hF, 4'h0, 3'd0, 8'h00, 1'b0};
        vt[9]  = '{1, 4'hF, 4'h0, 3'd3, 8'hF0, 1'b0};
        vt[10] = '{0, 4'hF, 4'h0, 3'd5, 8'hF0, 1'b0};
        vt[11] = '{1, 4'h3, 4'h5, 3'd2, 8'hFE, 1'b0};
        vt[12] = '{0, 4'h3, 4'h5, 3'd1, 8'h07, 1'b0};
        vt[13] = '{1, 4'h3, 4'h5, 3'd4, 8'h06, 1'b0};

        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        set_req(0, 4'h0, 4'h0, 3'd0);
        set_req(1, 4'h0, 4'h0, 3'd0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_req_ready", req_ready, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_req_ready", req_ready, 2'b00);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            txn(vt[i].id, vt[i].a, vt[i].b, vt[i].op, vt[i].exp_data, vt[i].ill);
        end

        // Both valid after reset: 0, 1, then back to 0
        do_reset();
        set_req(0, 4'hC, 4'hA, 3'd0);
        set_req(1, 4'hC, 4'hA, 3'd5);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rr_grant", req_ready, (k == 1) ? 2'b10 : 2'b01);
            @(negedge clk);
            if (k == 2) req_valid = 2'b00;
            #1;
            check("rr_exec_vld", rsp_valid, 1'b0);
            check("rr_exec_rdy", req_ready, 2'b00);
            @(negedge clk);
            #1;
            check("rr_rsp_vld", rsp_valid, 1'b1);
            check("rr_rsp_id", rsp_id, (k == 1) ? 1'b1 : 1'b0);
            check("rr_rsp_data", rsp_data, (k == 1) ? 8'hF9 : 8'h08);
            @(negedge clk);
        end

        // Backpressure: response held 5 cycles while req1 waits
        set_req(0, 4'hF, 4'h0, 3'd1);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        check("bp_grant0", req_ready, 2'b01);
        @(negedge clk);
        set_req(1, 4'h3, 4'h5, 3'd0);
        req_valid = 2'b10;
        #1;
        check("bp_exec_vld", rsp_valid, 1'b0);
        check("bp_exec_rdy", req_ready, 2'b00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("bp_hold_vld", rsp_valid, 1'b1);
            check("bp_hold_data", rsp_data, 8'h0F);
            check("bp_hold_id", rsp_id, 1'b0);
            check("bp_hold_rdy", req_ready, 2'b00);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("bp_last_vld", rsp_valid, 1'b1);
        check("bp_last_rdy", req_ready, 2'b00);
        @(negedge clk);
        #1;
        check("bp_done_vld", rsp_valid, 1'b0);
        check("bp_grant1", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("bp_exec2_vld", rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        check("bp_rsp2_vld", rsp_valid, 1'b1);
        check("bp_rsp2_id", rsp_id, 1'b1);
        check("bp_rsp2_data", rsp_data, 8'h01);

        // Serve req0 so the pointer moves to 1, then reset during req1's EXEC
        txn(0, 4'hC, 4'hA, 3'd1, 8'h0E, 1'b0);
        @(negedge clk);
        set_req(1, 4'hC, 4'hA, 3'd1);
        req_valid = 2'b10;
        #1;
        check("rx_grant1", req_ready, 2'b10);
        @(negedge clk);
        rst_n = 1'b0;
        set_req(0, 4'hC, 4'hA, 3'd0);
        req_valid = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rx_after_vld", rsp_valid, 1'b0);
        check("rx_after_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        check("rx_exec_vld", rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        check("rx_rsp0_vld", rsp_valid, 1'b1);
        check("rx_rsp0_id", rsp_id, 1'b0);
        check("rx_rsp0_data", rsp_data, 8'h08);
        @(negedge clk);
        #1;
        check("rx_grant1_again", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        check("rx_rsp1_vld", rsp_valid, 1'b1);
        check("rx_rsp1_id", rsp_id, 1'b1);
        check("rx_rsp1_data", rsp_data, 8'h0E);

        // Back-to-back: req1 always valid for 10 ops
        @(negedge clk);
        set_req(1, 4'hC, 4'hA, 3'd1);
        set_req(0, 4'h3, 4'h5, 3'd2);
        req_valid = 2'b10;
        rsp_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #1;
            check("b2b_rdy", req_ready, (c % 3 == 0) ? 2'b10 : 2'b00);
            check("b2b_vld", rsp_valid, (c % 3 == 2) ? 1'b1 : 1'b0);
            if (c % 3 == 2) begin
                check("b2b_id", rsp_id, 1'b1);
                check("b2b_data", rsp_data, 8'h0E);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1;
        check("b2b_end_vld", rsp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
